dmem_req_ctrl: RTL
==================

# dmem_req_ctrl

Request front-end placed directly upstream of the data memory. It accepts load/store requests from the CPU MEM stage over a valid/ready handshake and rejects misaligned accesses without touching memory. Accepted requests are issued to the data memory as a single-cycle enable pulse. The block tracks the memory's clock-stall handshake and returns one response (load data or store acknowledge) per request, with a timeout error if the memory never completes.

## Interface
- `TIMEOUT`, 15: maximum cycles spent in WAIT_HI plus WAIT_LO before an error response; 4-bit counter is sufficient for the default.
- `clk_i`  in  1  single clock; all state on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept; reset 0.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data.
- `req_sign_mask_i`  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2] 1 = unsigned load.
- `rsp_valid_o`  out  1  one-cycle response pulse; no backpressure; reset 0.
- `rsp_rdata_o`  out  32  load data; 0 for stores/errors; reset 0.
- `rsp_err_o`  out  1  misaligned, illegal size or timeout; reset 0.
- `busy_o`  out  1  high in every state except IDLE; reset 1.
- `mem_addr_o`, `mem_w_data_o`  out  32  registered request fields, stable from ISSUE until the next accept; reset 0.
- `mem_sign_mask_o`  out  3  registered; reset 0.
- `mem_w_ena_o`, `mem_r_ena_o`  out  1  high only in ISSUE; reset 0.
- `mem_r_data_i`  in  32  memory read data.
- `mem_stall_i`  in  1  memory busy (stall) flag.

## Operation
- States: FLUSH, IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP. Reset state is FLUSH.
- FLUSH: the memory has no reset and may be mid-access. Leave to IDLE on the first cycle `mem_stall_i`=0.
- IDLE: `req_ready_o`=1. On `req_valid_i`, register the request fields.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]≠0) or size 11 goes to RESP with err=1. No memory enable is raised.
  - All other requests go to ISSUE.
- ISSUE: assert `mem_w_ena_o`=we or `mem_r_ena_o`=~we for exactly this cycle, then go to WAIT_HI. Clear the timeout counter.
- WAIT_HI: wait for `mem_stall_i`=1, then go to WAIT_LO.
- WAIT_LO: on the first cycle with `mem_stall_i`=0, capture `mem_r_data_i` for loads (0 for stores), then go to RESP.
- The timeout counter increments each cycle in WAIT_HI/WAIT_LO. When it reaches TIMEOUT, go to RESP with err=1 and rdata=0, and return to FLUSH instead of IDLE afterwards.
- RESP: `rsp_valid_o`=1 for one cycle, then go to IDLE (or FLUSH after a timeout).
- Address regions, including MMIO/LED, are not decoded. Every aligned access uses the same memory handshake.

## Timing
- Acceptance in cycle 0 (edge at end of cycle 0).
  - ISSUE pulse in cycle 1.
  - Nominal memory stall covers cycles 2–3; capture in cycle 4.
  - `rsp_valid_o` in cycle 5; next acceptance is possible at the earliest in cycle 6.
- Error path for misaligned/illegal requests: accept in cycle 0, `rsp_valid_o`+`rsp_err_o` in cycle 1.
- Timeout path: `rsp_valid_o`+err in the cycle after the counter reaches TIMEOUT.
- `rsp_valid_o`, `rsp_rdata_o` and `rsp_err_o` are registered. `rsp_rdata_o`/`rsp_err_o` hold until the next response.
- Asserting `rst_i` at any point forces all outputs to their reset values immediately, including mid-ISSUE. Any in-flight request is dropped with no response.
- `req_valid_i` outside IDLE is ignored; the requester must hold it until it sees ready.

## Structure
- Package `dmem_pkg` holds:
  - the state encoding;
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD and the UNSIGNED bit index;
  - a function `is_misaligned(addr[1:0], size)`.
- One combinational sub-module `dmem_align_check` (inputs addr[1:0] and sign_mask; output err) is natural. Everything else stays in a single module.

## Test plan
- Word load at 0x1000_0004, memory model stalls cycles 2–3 returning 0xDEADBEEF → ISSUE pulse with r_ena in cycle 1 only; rsp_valid in cycle 5 with rdata=0xDEADBEEF, err=0.
- Half store at 0x1000_0003 → no mem enable ever raised; rsp_valid+err in cycle 1; req_ready high again in cycle 2.
- Byte store 0xAB at 0x2000 → single w_ena pulse, mem_w_data_o=0x000000AB stable through WAIT_LO; rsp err=0, rdata=0.
- Memory model never raises stall → rsp err=1 exactly TIMEOUT cycles after WAIT_HI entry; block enters FLUSH, then IDLE once stall is 0.
- Reset while in WAIT_LO with stall high → outputs zero at once; after release, req_ready stays 0 until stall drops, then a load completes normally.
- Two back-to-back requests with req_valid held → accepts in cycles 0 and 6, two rsp pulses in cycles 5 and 11.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory request front-end.
// Holds the FSM state encoding, access-size codes and the alignment rule.
// No logic of its own; imported by dmem_align_check and dmem_req_ctrl.
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_RESP    = 3'd5
  } dmem_state_e;

  // sign_mask[1:0] size codes, sign_mask[2] selects unsigned loads
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;
  localparam int         UNSIGNED   = 2;

  // Natural alignment: halves on even bytes, words on 4-byte boundaries
  function automatic logic is_misaligned(input logic [1:0] addr, input logic [1:0] size);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = addr[0];
      SZ_WORD: mis = (addr != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_align_check.sv
// Flags requests that must be rejected before reaching memory.
// Latency: purely combinational.
// Backpressure: none; evaluated on the request fields as presented.
module dmem_align_check
  import dmem_pkg::*;
(
  input  logic [1:0] addr_i,
  input  logic [2:0] sign_mask_i,
  output logic       err_o
);

  // The unsigned flag only affects how memory extends load data
  logic unused_unsigned;
  assign unused_unsigned = sign_mask_i[UNSIGNED];

  // Reject misaligned halves/words and the reserved size code
  always_comb begin
    err_o = is_misaligned(addr_i, sign_mask_i[1:0]) | (sign_mask_i[1:0] == SZ_ILLEGAL);
  end

endmodule

// File: rtl/dmem_req_ctrl.sv
// Data-memory request front-end: accepts, checks, issues and tracks one access at a time.
// Latency: accept->issue 1 cycle, response the cycle after memory drops stall (5 cycles nominal).
// Backpressure: req_ready_o only in IDLE; responses are pulses with no backpressure.
module dmem_req_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_sign_mask_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_w_data_o,
  output logic [2:0]  mem_sign_mask_o,
  output logic        mem_w_ena_o,
  output logic        mem_r_ena_o,
  input  logic [31:0] mem_r_data_i,
  input  logic        mem_stall_i
);

  localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  dmem_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_hit;
  logic             we_q;
  logic             flush_after_q;
  logic             ready_q, busy_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [31:0]      rsp_rdata_q;
  logic [31:0]      addr_q, wdata_q;
  logic [2:0]       sign_mask_q;
  logic             w_ena_q, r_ena_q;
  logic             align_err;

  dmem_align_check u_align (
    .addr_i      (req_addr_i[1:0]),
    .sign_mask_i (req_sign_mask_i),
    .err_o       (align_err)
  );

  // Wait-cycle counter arithmetic; the last wait cycle is the one before TIMEOUT
  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    timeout_hit = (cnt_q == CNT_LAST);
  end

  // Request FSM with all outputs registered alongside the state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_FLUSH;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      flush_after_q <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      sign_mask_q   <= '0;
      w_ena_q       <= 1'b0;
      r_ena_q       <= 1'b0;
    end else begin
      w_ena_q     <= 1'b0;
      r_ena_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        // Memory has no reset; wait for any access it was doing to finish
        ST_FLUSH: begin
          if (!mem_stall_i) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q          <= req_we_i;
            addr_q        <= req_addr_i;
            wdata_q       <= req_wdata_i;
            sign_mask_q   <= req_sign_mask_i;
            flush_after_q <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b1;
            if (align_err) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= ST_ISSUE;
              w_ena_q <= req_we_i;
              r_ena_q <= ~req_we_i;
            end
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          cnt_q <= cnt_d;
          if (timeout_hit) begin
            state_q       <= ST_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_rdata_q   <= '0;
            flush_after_q <= 1'b1;
          end else if (mem_stall_i) begin
            state_q <= ST_WAIT_LO;
          end
        end
        // A completion seen on the last wait cycle wins over the timeout
        ST_WAIT_LO: begin
          cnt_q <= cnt_d;
          if (!mem_stall_i) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? 32'h0 : mem_r_data_i;
          end else if (timeout_hit) begin
            state_q       <= ST_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_rdata_q   <= '0;
            flush_after_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (flush_after_q) begin
            state_q <= ST_FLUSH;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_FLUSH;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o     = ready_q;
  assign busy_o          = busy_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_err_o       = rsp_err_q;
  assign mem_addr_o      = addr_q;
  assign mem_w_data_o    = wdata_q;
  assign mem_sign_mask_o = sign_mask_q;
  assign mem_w_ena_o     = w_ena_q;
  assign mem_r_ena_o     = r_ena_q;

endmodule
